// File: rtl/uart_pkg.sv
// Shared constants, state codes and helpers for the UART receive path.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned CNT_W      = $clog2(OVERSAMPLE);
  localparam int unsigned STATE_W    = 3;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned IDX_W      = 3;

  localparam logic [CNT_W-1:0] SAMPLE_A  = CNT_W'(7);
  localparam logic [CNT_W-1:0] SAMPLE_B  = CNT_W'(8);
  localparam logic [CNT_W-1:0] SAMPLE_C  = CNT_W'(9);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVERSAMPLE - 1);

  localparam logic [STATE_W-1:0] IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] START  = 3'd1;
  localparam logic [STATE_W-1:0] DATA   = 3'd2;
  localparam logic [STATE_W-1:0] PARITY = 3'd3;
  localparam logic [STATE_W-1:0] STOP   = 3'd4;

  typedef logic [STATE_W-1:0] state_t;

  // Byte plus the status flags that travel with it to the consumer.
  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic              parity_err;
    logic              frame_err;
  } rx_frame_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync_edge_detect.sv
// Metastability synchroniser for the serial line and single-cycle tick
// generator from the rising edge of the 16x baud clock.
module sync_edge_detect
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_rx,
  input  logic i_clk_16bd,
  output logic o_rx_s,
  output logic o_tick_c
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_clk16_q;

  // Line idles high, so the chain resets to 1 to avoid a false start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync    <= '1;
      r_clk16_q <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_rx};
      r_clk16_q <= i_clk_16bd;
    end
  end

  assign o_rx_s   = r_sync[SYNC_STAGES-1];
  assign o_tick_c = i_clk_16bd & ~r_clk16_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampling, 3-sample majority vote, optional parity,
// framing/overrun flags and a valid/ready holding register for the byte.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_EN   = 0,
  parameter int unsigned PARITY_ODD  = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clk_16bd,
  input  logic              i_rx,
  output logic [BYTE_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  input  logic              i_rx_ready,
  output logic              o_parity_err,
  output logic              o_frame_err,
  output logic              o_overrun,
  output logic              o_busy
);

  logic w_rx_s;
  logic w_tick;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst        (rst),
    .i_rx       (i_rx),
    .i_clk_16bd (i_clk_16bd),
    .o_rx_s     (w_rx_s),
    .o_tick_c   (w_tick)
  );

  state_t                r_state,  w_state_nxt;
  logic [CNT_W-1:0]      r_cnt,    w_cnt_nxt;
  logic [IDX_W-1:0]      r_idx,    w_idx_nxt;
  logic [1:0]            r_samp,   w_samp_nxt;
  logic [DATA_BITS-1:0]  r_shift,  w_shift_nxt;
  logic                  r_par_err, w_par_err_nxt;
  rx_frame_t             r_hold,   w_hold_nxt;
  logic                  r_rx_valid, w_rx_valid_nxt;
  logic                  r_overrun,  w_overrun_nxt;
  logic                  r_busy,     w_busy_nxt;

  logic w_maj;
  logic w_done;
  logic w_acc;

  assign w_maj = majority3(r_samp[1], r_samp[0], w_rx_s);
  assign w_acc = r_rx_valid & i_rx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_samp     <= '0;
      r_shift    <= '0;
      r_par_err  <= 1'b0;
      r_hold     <= '0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_samp     <= w_samp_nxt;
      r_shift    <= w_shift_nxt;
      r_par_err  <= w_par_err_nxt;
      r_hold     <= w_hold_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_overrun  <= w_overrun_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Frame sequencing; everything advances only on baud ticks.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_samp_nxt    = r_samp;
    w_shift_nxt   = r_shift;
    w_par_err_nxt = r_par_err;
    w_done        = 1'b0;

    if (w_tick) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
      if (r_cnt == SAMPLE_A) w_samp_nxt[1] = w_rx_s;
      if (r_cnt == SAMPLE_B) w_samp_nxt[0] = w_rx_s;

      case (r_state)
        IDLE: begin
          w_cnt_nxt = '0;
          if (!w_rx_s) begin
            w_state_nxt   = START;
            w_par_err_nxt = 1'b0;
          end
        end
        START: begin
          if (r_cnt == SAMPLE_C && w_maj) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == LAST_TICK) begin
            w_state_nxt = DATA;
            w_idx_nxt   = '0;
          end
        end
        DATA: begin
          if (r_cnt == SAMPLE_C) w_shift_nxt = {w_maj, r_shift[DATA_BITS-1:1]};
          if (r_cnt == LAST_TICK) begin
            w_idx_nxt = r_idx + IDX_W'(1);
            if (r_idx == IDX_W'(DATA_BITS - 1))
              w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (r_cnt == SAMPLE_C)
            w_par_err_nxt = (^r_shift) ^ w_maj ^ (PARITY_ODD != 0);
          if (r_cnt == LAST_TICK) w_state_nxt = STOP;
        end
        STOP: begin
          // Leave at mid-stop so a start bit at the nominal stop end is caught.
          if (r_cnt == SAMPLE_C) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Holding register handshake and overrun tracking.
  always_comb begin
    w_hold_nxt     = r_hold;
    w_rx_valid_nxt = r_rx_valid;
    w_overrun_nxt  = r_overrun;
    w_busy_nxt     = (w_state_nxt != IDLE);

    if (w_acc) w_overrun_nxt = 1'b0;

    if (w_done && (!r_rx_valid || w_acc)) begin
      w_hold_nxt.data       = BYTE_W'(r_shift);
      w_hold_nxt.parity_err = (PARITY_EN != 0) ? r_par_err : 1'b0;
      w_hold_nxt.frame_err  = ~w_maj;
      w_rx_valid_nxt        = 1'b1;
    end else if (w_done) begin
      w_overrun_nxt = 1'b1;
    end else if (w_acc) begin
      w_rx_valid_nxt        = 1'b0;
      w_hold_nxt.parity_err = 1'b0;
      w_hold_nxt.frame_err  = 1'b0;
    end
  end

  assign o_rx_data    = r_hold.data;
  assign o_parity_err = r_hold.parity_err;
  assign o_frame_err  = r_hold.frame_err;
  assign o_rx_valid   = r_rx_valid;
  assign o_overrun    = r_overrun;
  assign o_busy       = r_busy;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver consuming the 16x-baud clock produced by the clock handler (clk_16bd) and the raw serial line.
- Oversamples each bit 16 times and majority-votes three mid-bit samples.
- Optionally checks parity; flags framing and overrun errors.
- Presents each received byte on a valid/ready holding register to downstream logic (command parser / VGA text-buffer writer).

Parameters:
- DATA_BITS, 8: data bits per frame (5..8); rx_data upper bits zero when <8.
- PARITY_EN, 0: 1 = one parity bit expected between data and stop.
- PARITY_ODD, 0: 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
- SYNC_STAGES, 2: flops in rx synchroniser (>=2).

Ports:
- clk, in, 1: system clock (100 MHz).
- rst, in, 1: reset.
- clk_16bd, in, 1: 16x baud clock from clock handler, treated as data in clk domain.
- rx, in, 1: asynchronous serial input, idle high.
- rx_data, out, 8: received byte, LSB = first data bit.
- rx_valid, out, 1: rx_data holds an unread byte.
- rx_ready, in, 1: consumer accepts byte when rx_valid & rx_ready.
- parity_err, out, 1: parity mismatch for held byte.
- frame_err, out, 1: stop bit sampled 0 for held byte.
- overrun, out, 1: sticky; a frame completed while the previous byte was unread.
- busy, out, 1: high in any state other than IDLE.

Interface: reset rst, asynchronous, active-high; clock clk. All flops reset asynchronously on rst=1.

Behaviour:
Reset values:
- rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
- state=IDLE; sample counter=0; rx synchroniser flops=1; clk_16bd edge flop=0.

Input conditioning:
- rx passes through SYNC_STAGES flops giving rx_s.
- tick = 1-clk pulse on each rising edge of clk_16bd (registered copy low, current high).
- clk_16bd rising edges are guaranteed >=2 clk apart.
- All state/counter updates below happen only on tick cycles, except the output handshake.

Counter and sampling:
- cnt is 4 bits, 0..15; increments per tick and wraps 15->0.
- Samples are captured at cnt=7, 8 and 9; bit value = majority of the three.

States:
- IDLE: on a tick with rx_s=0, go to START with cnt=0.
- START: at cnt=9, if majority=1 (glitch) return to IDLE, no flags. Otherwise continue; at cnt=15 go to DATA with bit index=0.
- DATA: at cnt=9, shift majority into the shift register (LSB first). At cnt=15, increment the bit index; after DATA_BITS bits go to PARITY if PARITY_EN, else STOP.
- PARITY: at cnt=9, compute the error as XOR of data bits ^ sampled bit ^ PARITY_ODD, nonzero = error. At cnt=15 go to STOP.
- STOP: at cnt=9, frame_err_n = ~majority, complete the frame, go to IDLE. The early exit allows resync to a start bit arriving at the nominal stop end.

Frame completion (the clk cycle of the STOP cnt=9 tick), let acc = rx_valid & rx_ready:
- rx_valid=0 or acc=1: load rx_data, parity_err, frame_err; rx_valid=1 next cycle (latency 1 clk after the tick).
- rx_valid=1 and acc=0: new frame dropped; held byte and its flags unchanged; overrun=1.
- Frames with frame_err/parity_err are still delivered, with the flags.

Handshake:
- acc with no completion: rx_valid=0 next cycle; parity_err and frame_err cleared.
- overrun clears on the first acc after it was set, unless a drop occurs in that same cycle.
- rx_ready while rx_valid=0 has no effect.
- rx_data stable while rx_valid=1 and not accepted.

Reset mid-frame: everything returns to reset values immediately; the next falling edge after rst release starts a fresh frame.

busy = (state != IDLE).

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, PARITY, STOP};
  - OVERSAMPLE=16; SAMPLE_A=7, SAMPLE_B=8, SAMPLE_C=9; LAST_TICK=15.
- One sub-module, sync_edge_detect: SYNC_STAGES synchroniser for rx plus rising-edge pulse generator for clk_16bd.

Test Plan:
Bench drives clk_16bd with period 16 clk; one bit = 16 ticks.
1. Frame 0x55 (start, 1,0,1,0,1,0,1,0, stop), rx_ready=1 -> rx_valid pulses 1 clk, rx_data=0x55, all flags 0, busy low after the stop mid-sample.
2. rx low for 4 ticks then high -> no rx_valid, busy returns 0 at START cnt=9, no flags.
3. Byte 0xA3 with stop=0 -> rx_data=0xA3, frame_err=1; next good frame 0x0F -> frame_err=0.
4. rx_ready=0; send 0x11 then 0x22 -> rx_data stays 0x11, overrun=1. Assert rx_ready one cycle -> rx_valid=0, overrun=0.
5. PARITY_EN=1 even: 0x07 with parity bit 0 -> parity_err=1; with parity bit 1 -> parity_err=0.
6. Single-tick low glitch at cnt=8 inside a '1' data bit of 0xFF -> rx_data=0xFF. Assert rst mid-DATA -> outputs reset; following 0x3C received correctly.
